// File: rtl/line_upscale_reader_pkg.sv
// ============================================================================
//  Module  : line_upscale_reader_pkg
//  Brief   : Shared line-buffer read-side types: FSM state encoding and the
//            scale-factor sanitiser used by the upscale reader.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package line_upscale_reader_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_DATA_W    = 24;
    localparam int DEF_SLOT_BITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // A zero scale factor behaves as x1.
    function automatic logic [2:0] eff_scale(input logic [2:0] s);
        return (s == 3'd0) ? 3'd1 : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_upscale_reader.sv
// ============================================================================
//  Module  : line_upscale_reader
//  Brief   : Line-buffer port-B reader; replicates each pixel hscale times and
//            each source line vscale times in the output pixel clock domain.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module line_upscale_reader
    import line_upscale_reader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int SRC_WIDTH = 320,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [2:0]        hscale,
    input  logic [2:0]        vscale,
    input  logic [CNT_W-1:0]  wr_lines_done,
    output logic [ADDR_W-1:0] adb,
    output logic              ceb,
    output logic              oce,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              line_done,
    output logic              underflow
);

    localparam int              PX_W    = ADDR_W - SLOT_BITS;
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(SRC_WIDTH - 1);

    state_t            state_q, state_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic [2:0]        hcnt_q, hcnt_d;
    logic [2:0]        hs_q, hs_d;
    logic [2:0]        vs_q, vs_d;
    logic [2:0]        rep_q, rep_d;
    logic              scale_load_q, scale_load_d;
    logic [CNT_W-1:0]  src_line_q, src_line_d;
    logic              underflow_q, underflow_d;
    logic              drain_q, drain_d;
    logic              ceb_q, ceb_d;
    logic [ADDR_W-1:0] adb_q, adb_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_blank_q, s1_blank_d;
    logic              s1_last_q, s1_last_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              line_done_q, line_done_d;

    logic              reload;
    logic              hstep;
    logic              line_end;
    logic [CNT_W-1:0]  start_line;

    always_comb begin
        // Scales are resampled on frame_start and on the first cycle after reset.
        reload     = frame_start || scale_load_q;
        hstep      = (hcnt_q == hs_q - 3'd1);
        line_end   = hstep && (px_q == PX_LAST);
        start_line = frame_start ? '0 : src_line_q;

        state_d      = state_q;
        px_d         = px_q;
        hcnt_d       = hcnt_q;
        hs_d         = reload ? eff_scale(hscale) : hs_q;
        vs_d         = reload ? eff_scale(vscale) : vs_q;
        scale_load_d = 1'b0;
        src_line_d   = src_line_q;
        rep_d        = rep_q;
        underflow_d  = underflow_q;
        drain_d      = drain_q;
        ceb_d        = ceb_q;
        adb_d        = adb_q;
        s1_valid_d   = 1'b0;
        s1_blank_d   = 1'b0;
        s1_last_d    = 1'b0;
        pix_valid_d  = 1'b0;
        line_done_d  = 1'b0;
        pix_data_d   = '0;

        if (frame_start) begin
            state_d     = ST_IDLE;
            ceb_d       = 1'b0;
            src_line_d  = '0;
            rep_d       = '0;
            underflow_d = 1'b0;
        end else begin
            pix_valid_d = s1_valid_q;
            line_done_d = s1_last_q;
            if (s1_valid_q && !s1_blank_q) begin
                pix_data_d = ram_dout;
            end
            unique case (state_q)
                ST_ACTIVE, ST_BLANK: begin
                    s1_valid_d = 1'b1;
                    s1_blank_d = (state_q == ST_BLANK);
                    s1_last_d  = line_end;
                    if (line_end) begin
                        state_d = ST_DRAIN;
                        ceb_d   = 1'b0;
                        drain_d = 1'b0;
                        hcnt_d  = '0;
                        // Blank lines retry the same source line next time.
                        if (state_q == ST_ACTIVE) begin
                            if (rep_q == vs_q - 3'd1) begin
                                rep_d      = '0;
                                src_line_d = src_line_q + CNT_W'(1);
                            end else begin
                                rep_d = rep_q + 3'd1;
                            end
                        end
                    end else if (hstep) begin
                        hcnt_d = '0;
                        px_d   = px_q + PX_W'(1);
                        adb_d  = {adb_q[ADDR_W-1:PX_W], px_q + PX_W'(1)};
                    end else begin
                        hcnt_d = hcnt_q + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_d = ST_IDLE;
                    end
                    drain_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (line_start && (frame_start || state_q == ST_IDLE)) begin
            px_d   = '0;
            hcnt_d = '0;
            adb_d  = {start_line[SLOT_BITS-1:0], PX_W'(0)};
            if (start_line < wr_lines_done) begin
                state_d = ST_ACTIVE;
                ceb_d   = 1'b1;
            end else begin
                state_d     = ST_BLANK;
                ceb_d       = 1'b0;
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            px_q         <= '0;
            hcnt_q       <= '0;
            hs_q         <= 3'd1;
            vs_q         <= 3'd1;
            rep_q        <= '0;
            scale_load_q <= 1'b1;
            src_line_q   <= '0;
            underflow_q  <= 1'b0;
            drain_q      <= 1'b0;
            ceb_q        <= 1'b0;
            adb_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_blank_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            px_q         <= px_d;
            hcnt_q       <= hcnt_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            rep_q        <= rep_d;
            scale_load_q <= scale_load_d;
            src_line_q   <= src_line_d;
            underflow_q  <= underflow_d;
            drain_q      <= drain_d;
            ceb_q        <= ceb_d;
            adb_q        <= adb_d;
            s1_valid_q   <= s1_valid_d;
            s1_blank_q   <= s1_blank_d;
            s1_last_q    <= s1_last_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            line_done_q  <= line_done_d;
        end
    end

    assign adb       = adb_q;
    assign ceb       = ceb_q;
    assign oce       = 1'b1;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign line_done = line_done_q;
    assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_line_upscale_reader.sv
// ============================================================================
//  Module  : tb_line_upscale_reader
//  Brief   : Self-checking bench: RAM model plus a line/pixel reference model.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_line_upscale_reader;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 24;
    localparam int SLOT_BITS = 3;
    localparam int SRC_W     = 4;
    localparam int CNT_W     = 10;
    localparam int SLOT_SIZE = 1 << (ADDR_W - SLOT_BITS);
    localparam int NSLOTS    = 1 << SLOT_BITS;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              line_start;
    logic [2:0]        hscale;
    logic [2:0]        vscale;
    logic [CNT_W-1:0]  wr_lines_done;
    logic [ADDR_W-1:0] adb;
    logic              ceb;
    logic              oce;
    logic [DATA_W-1:0] ram_dout = '0;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              line_done;
    logic              underflow;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_src, m_rep, m_hs, m_vs;
    bit m_under;
    logic [DATA_W-1:0] exp_pix[$];
    logic [ADDR_W-1:0] exp_addr[$];

    // Observed line
    logic [DATA_W-1:0] obs_pix[$];
    logic [ADDR_W-1:0] obs_addr[$];
    int obs_first, obs_last, obs_done_cyc, obs_done_cnt;

    line_upscale_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLOT_BITS(SLOT_BITS),
        .SRC_WIDTH(SRC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .hscale(hscale), .vscale(vscale), .wr_lines_done(wr_lines_done),
        .adb(adb), .ceb(ceb), .oce(oce), .ram_dout(ram_dout),
        .pix_data(pix_data), .pix_valid(pix_valid), .line_done(line_done),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ceb) ram_dout <= mem[adb];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int eff(input logic [2:0] s);
        return (s == 3'd0) ? 1 : int'(s);
    endfunction

    task automatic model_frame_start();
        m_src = 0; m_rep = 0; m_under = 0;
        m_hs = eff(hscale); m_vs = eff(vscale);
    endtask

    // Expected pixels/addresses for the next requested line, then advance the model.
    task automatic model_line();
        bit blank;
        exp_pix.delete(); exp_addr.delete();
        blank = (m_src >= int'(wr_lines_done));
        for (int p = 0; p < SRC_W; p++) begin
            for (int r = 0; r < m_hs; r++) begin
                int a;
                a = (m_src % NSLOTS) * SLOT_SIZE + p;
                exp_pix.push_back(blank ? '0 : mem[a]);
                if (!blank) exp_addr.push_back(ADDR_W'(a));
            end
        end
        if (blank) m_under = 1;
        else begin
            m_rep++;
            if (m_rep == m_vs) begin m_rep = 0; m_src++; end
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        model_frame_start();
    endtask

    // Issue line_start in the current cycle and record DUT activity until idle.
    task automatic run_line(input int ls_again, input bit fs);
        obs_pix.delete(); obs_addr.delete();
        obs_first = -1; obs_last = -1; obs_done_cyc = -1; obs_done_cnt = 0;
        line_start = 1'b1;
        frame_start = fs;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            line_start  = (c == ls_again);
            frame_start = 1'b0;
            if (ceb) obs_addr.push_back(adb);
            if (pix_valid) begin
                obs_pix.push_back(pix_data);
                if (obs_first < 0) obs_first = c;
                obs_last = c;
            end
            if (line_done) begin obs_done_cnt++; obs_done_cyc = c; end
            if (obs_done_cnt > 0 && c > obs_done_cyc) break;
        end
        line_start = 1'b0;
    endtask

    task automatic test_lines(input string name, input int n, input bit ramp,
                              input int ls_again, input bit fs_first);
        for (int l = 0; l < n; l++) begin
            bit fs;
            int bad;
            fs = fs_first && (l == 0);
            if (fs) begin
                m_src = 0; m_rep = 0; m_under = 0;
                m_hs = eff(hscale); m_vs = eff(vscale);
            end
            if (ramp) wr_lines_done = CNT_W'(m_src + 1);
            model_line();
            run_line(ls_again, fs);
            checks++;
            if (obs_done_cnt == 0) begin
                errors++;
                $display("FAIL %s line %0d done_timeout: got no line_done, required one", name, l);
            end else begin
                checks++;
                if (obs_first !== 3) begin
                    errors++;
                    $display("FAIL %s line %0d first_valid_cycle: got %0d, required 3", name, l, obs_first);
                end
                checks++;
                if (obs_pix.size() != exp_pix.size() || obs_last - obs_first + 1 != exp_pix.size()) begin
                    errors++;
                    $display("FAIL %s line %0d valid_run: got %0d valid over %0d cycles, required %0d contiguous",
                             name, l, obs_pix.size(), obs_last - obs_first + 1, exp_pix.size());
                end
                checks++;
                bad = -1;
                for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
                    if (bad < 0 && obs_pix[i] !== exp_pix[i]) bad = i;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL %s line %0d pix_data[%0d]: got %h, required %h",
                             name, l, bad, obs_pix[bad], exp_pix[bad]);
                end
                checks++;
                bad = (obs_addr.size() != exp_addr.size()) ? 0 : -1;
                for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
                    if (bad < 0 && obs_addr[i] !== exp_addr[i]) bad = i;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL %s line %0d adb[%0d]: got %0d (n=%0d), required %0d (n=%0d)", name, l, bad,
                             (bad < obs_addr.size()) ? int'(obs_addr[bad]) : -1, obs_addr.size(),
                             (bad < exp_addr.size()) ? int'(exp_addr[bad]) : -1, exp_addr.size());
                end
                checks++;
                if (obs_done_cnt != 1 || obs_done_cyc != obs_last) begin
                    errors++;
                    $display("FAIL %s line %0d line_done: got %0d pulses last at %0d, required 1 at %0d",
                             name, l, obs_done_cnt, obs_done_cyc, obs_last);
                end
            end
            checks++;
            if (underflow !== m_under) begin
                errors++;
                $display("FAIL %s line %0d underflow: got %b, required %b", name, l, underflow, m_under);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
        hscale = 3'd1; vscale = 3'd1; wr_lines_done = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom) | 24'h000001;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (adb !== '0)       begin errors++; $display("FAIL reset adb: got %0d, required 0", adb); end
        checks++; if (ceb !== 1'b0)     begin errors++; $display("FAIL reset ceb: got %b, required 0", ceb); end
        checks++; if (oce !== 1'b1)     begin errors++; $display("FAIL reset oce: got %b, required 1", oce); end
        checks++; if (pix_data !== '0)  begin errors++; $display("FAIL reset pix_data: got %h, required 0", pix_data); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset pix_valid: got %b, required 0", pix_valid); end
        checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset line_done: got %b, required 0", line_done); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset underflow: got %b, required 0", underflow); end
        reset = 1'b0;
        model_frame_start();
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        hscale = 3'd1; vscale = 3'd1; wr_lines_done = CNT_W'(1);
        pulse_frame_start();
        test_lines("basic", 1, 0, -1, 0);
    endtask

    task automatic test_scaled();
        hscale = 3'd3; vscale = 3'd2; wr_lines_done = CNT_W'(2);
        pulse_frame_start();
        test_lines("scaled", 4, 0, -1, 0);
    endtask

    task automatic test_underflow();
        hscale = 3'd1; vscale = 3'd1; wr_lines_done = '0;
        pulse_frame_start();
        test_lines("underflow", 1, 0, -1, 0);
        wr_lines_done = CNT_W'(1);
        test_lines("underflow_recover", 1, 0, -1, 0);
    endtask

    task automatic test_frame_abort();
        int bad_valid, done_seen;
        hscale = 3'd1; vscale = 3'd2; wr_lines_done = '0;
        pulse_frame_start();
        test_lines("abort_pre_blank", 1, 0, -1, 0);
        wr_lines_done = CNT_W'(1);
        test_lines("abort_pre", 1, 0, -1, 0);
        wr_lines_done = CNT_W'(2);
        bad_valid = 0; done_seen = 0;
        line_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            line_start  = 1'b0;
            frame_start = (c == 4);
            if ((c == 3 || c == 4) && pix_valid !== 1'b1) bad_valid++;
            if (c >= 5 && pix_valid !== 1'b0) bad_valid++;
            if (line_done) done_seen++;
            if (c == 5) begin
                checks++;
                if (ceb !== 1'b0 || underflow !== 1'b0) begin
                    errors++;
                    $display("FAIL abort ceb_underflow: got ceb=%b underflow=%b, required 0 0", ceb, underflow);
                end
            end
        end
        model_frame_start();
        checks++;
        if (bad_valid != 0) begin
            errors++;
            $display("FAIL abort pix_valid: got %0d wrong cycles, required 0", bad_valid);
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort line_done: got %0d pulses, required 0", done_seen);
        end
        test_lines("after_abort", 2, 0, -1, 0);
        hscale = 3'd2; vscale = 3'd1; wr_lines_done = CNT_W'(1);
        test_lines("fs_with_ls", 2, 0, -1, 1);
    endtask

    task automatic test_slot_wrap();
        hscale = 3'd1; vscale = 3'd1;
        pulse_frame_start();
        test_lines("slot_wrap", 10, 1, 2, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            hscale = 3'($urandom_range(0, 7));
            vscale = 3'($urandom_range(0, 7));
            wr_lines_done = CNT_W'($urandom_range(0, 3));
            pulse_frame_start();
            test_lines("random", 5, 0, -1, 0);
        end
    endtask

    task automatic test_reset_midline();
        hscale = 3'd3; vscale = 3'd1; wr_lines_done = '0;
        pulse_frame_start();
        test_lines("rst_pre_blank", 1, 0, -1, 0);
        wr_lines_done = CNT_W'(3);
        test_lines("rst_pre", 1, 0, -1, 0);
        line_start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            line_start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (adb !== '0 || ceb !== 1'b0 || oce !== 1'b1 || pix_data !== '0 ||
            pix_valid !== 1'b0 || line_done !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL midline_reset outputs: got adb=%0d ceb=%b oce=%b pix=%h v=%b done=%b uf=%b, required 0 0 1 0 0 0 0",
                     adb, ceb, oce, pix_data, pix_valid, line_done, underflow);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_frame_start();
        test_lines("after_reset", 1, 0, -1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scaled();
        test_underflow();
        test_frame_abort();
        test_slot_wrap();
        test_random();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
